hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage ARM32 core. Drives the forwarding selects of the EXE stage
//  (sel_src1_FWRD/sel_src2_FWRD), detects RAW/load-use hazards, flushes IF/ID on taken branches,
//  and freezes the whole pipeline while the MEM stage waits on a multi-cycle SRAM (ready handshake).
//  Keeps saturating stall/flush performance counters and a sticky SRAM-timeout error.
// PARAMETERS
//  TIMEOUT  64  max SRAM wait cycles before sram_err is raised; legal 2..2**16
//  CNT_W    16  width of perf counters stall_cnt / flush_cnt
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   asynchronous reset, active-high
//  forward_en    in   1   1 = forwarding on (load-use stalls only); 0 = stall on every RAW hazard
//  src1_ID       in   4   Rn of instruction in ID
//  src2_ID       in   4   Rm/Rd of instruction in ID
//  two_src_ID    in   1   ID instruction reads src2_ID
//  src1_EXE      in   4   Rn of instruction in EXE
//  src2_EXE      in   4   Rm of instruction in EXE
//  dest_EXE      in   4   dest of EXE instruction
//  WB_EN_EXE     in   1   EXE instruction writes back
//  MEM_R_EN_EXE  in   1   EXE instruction is a load
//  B_EXE         in   1   taken branch resolved in EXE
//  dest_MEM      in   4   dest of MEM instruction
//  WB_EN_MEM     in   1   MEM instruction writes back
//  mem_req_MEM   in   1   MEM stage issues SRAM read/write this cycle
//  sram_ready    in   1   SRAM completes access this cycle
//  dest_WB       in   4   dest of WB instruction
//  WB_EN_WB      in   1   WB instruction writes back
//  sel_src1_FWRD out  2   0=reg file, 1=alu_res_MEM, 2=val_WB
//  sel_src2_FWRD out  2   same encoding for Rm path
//  freeze        out  1   hold all pipeline registers and PC
//  hazard        out  1   hold PC and IF/ID reg; insert bubble into ID/EXE
//  flush         out  1   clear IF/ID and ID/EXE regs (branch kill)
//  stall_cnt     out  CNT_W  cycles with freeze|hazard, saturating
//  flush_cnt     out  CNT_W  count of flush cycles, saturating
//  sram_err      out  1   sticky: SRAM wait reached TIMEOUT
// BEHAVIOUR
//  FSM: RUN, WAIT, ERR (2-bit, registered). Reset -> RUN; wait_ctr, stall_cnt, flush_cnt,
//   sram_err = 0. While rst high all combinational outputs forced 0.
//  RUN : mem_req_MEM & !sram_ready -> WAIT, wait_ctr<=1. Else stay.
//  WAIT: sram_ready -> RUN, wait_ctr<=0. Else if wait_ctr==TIMEOUT-1 -> ERR, sram_err<=1.
//        Else wait_ctr++.
//  ERR : terminal until rst; freeze=1 permanently.
//  freeze = (state!=ERR & mem_req_MEM & !sram_ready) | (state==ERR). Combinational in ready:
//   ready-in-same-cycle access costs zero stall cycles; WAIT exits freeze on the ready cycle.
//  Forwarding (combinational, only when forward_en, else both sels 0): sel_src1=1 if WB_EN_MEM &
//   dest_MEM==src1_EXE; else 2 if WB_EN_WB & dest_WB==src1_EXE; else 0. MEM wins over WB.
//   sel_src2 identical using src2_EXE.
//  RAW match m(x,d,en) = en & (src1_ID==d | two_src_ID & src2_ID==d).
//   forward_en=1: hazard = m(_,dest_EXE,WB_EN_EXE & MEM_R_EN_EXE)  (load-use only).
//   forward_en=0: hazard = m(_,dest_EXE,WB_EN_EXE) | m(_,dest_MEM,WB_EN_MEM).
//  flush = B_EXE.
//  Priority: freeze > flush > hazard. While freeze=1, flush and hazard are 0 (branch and hazard
//   re-evaluated once unfrozen, inputs unchanged). flush=1 forces hazard=0 (offender is killed).
//  stall_cnt += 1 each cycle freeze|hazard; flush_cnt += 1 each cycle flush; both saturate at
//   2**CNT_W-1, no wrap.
//  Async rst mid-WAIT: immediately RUN, counters cleared, sram_err cleared.
// TESTING
//  1 fwd_en=1, MEM dest=R3 WB_EN, WB dest=R3 WB_EN, src1_EXE=3 -> sel_src1=1; drop WB_EN_MEM -> 2.
//  2 fwd_en=1, EXE load dest=R5, src2_ID=5 two_src=1 -> hazard=1 one cycle; non-load dest R5 -> 0.
//  3 fwd_en=0, WB_EN_MEM dest=R2, src1_ID=2 -> hazard=1, sel_src1/2=0 regardless of matches.
//  4 mem_req=1, ready after 3 cycles -> freeze high 3 cycles, low on ready cycle, stall_cnt=3.
//  5 TIMEOUT=4, ready never -> sram_err=1 after 4th wait cycle, freeze stuck; rst clears all.
//  6 B_EXE=1 with load-use match -> flush=1, hazard=0, flush_cnt+1; same with freeze -> flush=0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: stage register/dest info in, forwarding selects,
// pipeline control and perf/error status out.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             forward_en;
  logic [3:0]       src1_ID;
  logic [3:0]       src2_ID;
  logic             two_src_ID;
  logic [3:0]       src1_EXE;
  logic [3:0]       src2_EXE;
  logic [3:0]       dest_EXE;
  logic             WB_EN_EXE;
  logic             MEM_R_EN_EXE;
  logic             B_EXE;
  logic [3:0]       dest_MEM;
  logic             WB_EN_MEM;
  logic             mem_req_MEM;
  logic             sram_ready;
  logic [3:0]       dest_WB;
  logic             WB_EN_WB;
  logic [1:0]       sel_src1_FWRD;
  logic [1:0]       sel_src2_FWRD;
  logic             freeze;
  logic             hazard;
  logic             flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             sram_err;

  // Pipeline side
  modport master (
    output forward_en, src1_ID, src2_ID, two_src_ID, src1_EXE, src2_EXE, dest_EXE,
           WB_EN_EXE, MEM_R_EN_EXE, B_EXE, dest_MEM, WB_EN_MEM, mem_req_MEM, sram_ready,
           dest_WB, WB_EN_WB,
    input  sel_src1_FWRD, sel_src2_FWRD, freeze, hazard, flush, stall_cnt, flush_cnt, sram_err
  );

  // Controller side
  modport slave (
    input  forward_en, src1_ID, src2_ID, two_src_ID, src1_EXE, src2_EXE, dest_EXE,
           WB_EN_EXE, MEM_R_EN_EXE, B_EXE, dest_MEM, WB_EN_MEM, mem_req_MEM, sram_ready,
           dest_WB, WB_EN_WB,
    output sel_src1_FWRD, sel_src2_FWRD, freeze, hazard, flush, stall_cnt, flush_cnt, sram_err
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: EXE forwarding selects, RAW/load-use hazard
// detection, branch flush and SRAM-wait freeze with timeout, plus saturating perf counters.
module hazard_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hif
);
  localparam int unsigned WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_ctr, wait_nxt;
  logic              err_q, err_nxt;
  logic [CNT_W-1:0]  stall_q, flush_q;

  logic [1:0]        sel1_c, sel2_c;
  logic              freeze_c, hazard_c, flush_c;
  logic              miss_c, raw_exe_c, raw_mem_c, raw_c;

  // State, wait counter, sticky error and saturating perf counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_RUN;
      wait_ctr <= '0;
      err_q    <= 1'b0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      state    <= state_nxt;
      wait_ctr <= wait_nxt;
      err_q    <= err_nxt;
      if ((freeze_c || hazard_c) && (stall_q != {CNT_W{1'b1}}))
        stall_q <= stall_q + CNT_W'(1);
      if (flush_c && (flush_q != {CNT_W{1'b1}}))
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  // Next state plus all combinational pipeline controls
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_ctr;
    err_nxt   = err_q;
    sel1_c    = 2'd0;
    sel2_c    = 2'd0;

    miss_c = hif.mem_req_MEM && !hif.sram_ready;

    unique case (state)
      S_RUN: begin
        if (miss_c) begin
          state_nxt = S_WAIT;
          wait_nxt  = WAIT_W'(1);
        end
      end
      S_WAIT: begin
        if (hif.sram_ready) begin
          state_nxt = S_RUN;
          wait_nxt  = '0;
        end else if (wait_ctr == WAIT_W'(TIMEOUT - 1)) begin
          state_nxt = S_ERR;
          err_nxt   = 1'b1;
        end else begin
          wait_nxt = wait_ctr + WAIT_W'(1);
        end
      end
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_RUN;
    endcase

    // MEM result is newer than WB, so it wins when both match
    if (hif.forward_en) begin
      if (hif.WB_EN_MEM && (hif.dest_MEM == hif.src1_EXE))     sel1_c = 2'd1;
      else if (hif.WB_EN_WB && (hif.dest_WB == hif.src1_EXE)) sel1_c = 2'd2;
      if (hif.WB_EN_MEM && (hif.dest_MEM == hif.src2_EXE))     sel2_c = 2'd1;
      else if (hif.WB_EN_WB && (hif.dest_WB == hif.src2_EXE)) sel2_c = 2'd2;
    end

    raw_exe_c = (hif.src1_ID == hif.dest_EXE) ||
                (hif.two_src_ID && (hif.src2_ID == hif.dest_EXE));
    raw_mem_c = (hif.src1_ID == hif.dest_MEM) ||
                (hif.two_src_ID && (hif.src2_ID == hif.dest_MEM));
    if (hif.forward_en)
      raw_c = hif.WB_EN_EXE && hif.MEM_R_EN_EXE && raw_exe_c;
    else
      raw_c = (hif.WB_EN_EXE && raw_exe_c) || (hif.WB_EN_MEM && raw_mem_c);

    // freeze > flush > hazard; everything held low during reset
    freeze_c = !rst && ((state == S_ERR) || miss_c);
    flush_c  = !rst && !freeze_c && hif.B_EXE;
    hazard_c = !rst && !freeze_c && !flush_c && raw_c;
    if (rst) begin
      sel1_c = 2'd0;
      sel2_c = 2'd0;
    end
  end

  assign hif.sel_src1_FWRD = sel1_c;
  assign hif.sel_src2_FWRD = sel2_c;
  assign hif.freeze        = freeze_c;
  assign hif.hazard        = hazard_c;
  assign hif.flush         = flush_c;
  assign hif.stall_cnt     = stall_q;
  assign hif.flush_cnt     = flush_q;
  assign hif.sram_err      = err_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then random traffic, all checked
// against a cycle-level behavioural model of the pipeline-control rules.
module tb_hazard_ctrl;
  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned CNT_W   = 4;
  localparam int          CMAX    = (1 << CNT_W) - 1;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  // model state
  int   m_waited;
  bit   m_err;
  int   m_stall;
  int   m_flush;
  bit   e_fr, e_hz, e_fl;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

  hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hif (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_sel(input logic [3:0] src);
    if (rst || !hif.forward_en) return 2'd0;
    if (hif.WB_EN_MEM && hif.dest_MEM == src) return 2'd1;
    if (hif.WB_EN_WB && hif.dest_WB == src) return 2'd2;
    return 2'd0;
  endfunction

  function automatic bit reads(input logic [3:0] d);
    return (hif.src1_ID == d) || (hif.two_src_ID && hif.src2_ID == d);
  endfunction

  task automatic model_reset();
    m_waited = 0;
    m_err    = 0;
    m_stall  = 0;
    m_flush  = 0;
  endtask

  task automatic clr_in();
    hif.forward_en   = 1'b1;
    hif.src1_ID      = 4'd0;  hif.src2_ID  = 4'd0;  hif.two_src_ID = 1'b0;
    hif.src1_EXE     = 4'd0;  hif.src2_EXE = 4'd0;  hif.dest_EXE   = 4'd15;
    hif.WB_EN_EXE    = 1'b0;  hif.MEM_R_EN_EXE = 1'b0; hif.B_EXE = 1'b0;
    hif.dest_MEM     = 4'd15; hif.WB_EN_MEM = 1'b0;
    hif.mem_req_MEM  = 1'b0;  hif.sram_ready = 1'b0;
    hif.dest_WB      = 4'd15; hif.WB_EN_WB = 1'b0;
  endtask

  // Check all combinational outputs against the rules for the current inputs
  task automatic check_comb();
    bit raw;
    e_fr = !rst && (m_err || (hif.mem_req_MEM && !hif.sram_ready));
    e_fl = !rst && !e_fr && hif.B_EXE;
    if (hif.forward_en)
      raw = hif.WB_EN_EXE && hif.MEM_R_EN_EXE && reads(hif.dest_EXE);
    else
      raw = (hif.WB_EN_EXE && reads(hif.dest_EXE)) || (hif.WB_EN_MEM && reads(hif.dest_MEM));
    e_hz = !rst && !e_fr && !e_fl && raw;
    check("sel_src1", 32'(hif.sel_src1_FWRD), 32'(exp_sel(hif.src1_EXE)));
    check("sel_src2", 32'(hif.sel_src2_FWRD), 32'(exp_sel(hif.src2_EXE)));
    check("freeze",   32'(hif.freeze), 32'(e_fr));
    check("flush",    32'(hif.flush),  32'(e_fl));
    check("hazard",   32'(hif.hazard), 32'(e_hz));
  endtask

  task automatic check_regs();
    check("stall_cnt", 32'(hif.stall_cnt), 32'(m_stall));
    check("flush_cnt", 32'(hif.flush_cnt), 32'(m_flush));
    check("sram_err",  32'(hif.sram_err),  32'(m_err));
  endtask

  // One clock: inputs already applied at posedge+1
  task automatic cycle();
    #2;
    check_comb();
    @(posedge clk);
    if (e_fr || e_hz) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
    if (e_fl)         m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
    if (!m_err) begin
      if (m_waited == 0) begin
        if (hif.mem_req_MEM && !hif.sram_ready) m_waited = 1;
      end else if (hif.sram_ready) begin
        m_waited = 0;
      end else begin
        m_waited++;
        if (m_waited == TIMEOUT) m_err = 1;
      end
    end
    #1;
    check_regs();
  endtask

  // Async reset: effects visible before any clock edge
  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_comb();
    check_regs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    clr_in();
    model_reset();
    @(posedge clk);
    #1;
    check_comb();
    check_regs();
    rst = 1'b0;

    // 1: forwarding, MEM beats WB, then WB alone
    hif.WB_EN_MEM = 1'b1; hif.dest_MEM = 4'd3; hif.WB_EN_WB = 1'b1; hif.dest_WB = 4'd3;
    hif.src1_EXE = 4'd3;
    #2 check("t1_mem_wins", 32'(hif.sel_src1_FWRD), 32'd1);
    cycle();
    hif.WB_EN_MEM = 1'b0;
    #2 check("t1_wb_fwd", 32'(hif.sel_src1_FWRD), 32'd2);
    cycle();
    clr_in();

    // 2: load-use on src2 stalls, non-load does not
    hif.WB_EN_EXE = 1'b1; hif.MEM_R_EN_EXE = 1'b1; hif.dest_EXE = 4'd5;
    hif.src2_ID = 4'd5; hif.two_src_ID = 1'b1; hif.src1_ID = 4'd1;
    #2 check("t2_load_use", 32'(hif.hazard), 32'd1);
    cycle();
    hif.MEM_R_EN_EXE = 1'b0;
    #2 check("t2_no_load", 32'(hif.hazard), 32'd0);
    cycle();
    clr_in();

    // 3: forwarding off stalls on MEM dest and zeroes selects
    hif.forward_en = 1'b0; hif.WB_EN_MEM = 1'b1; hif.dest_MEM = 4'd2; hif.src1_ID = 4'd2;
    hif.src1_EXE = 4'd2; hif.src2_EXE = 4'd2;
    #2 check("t3_hazard", 32'(hif.hazard), 32'd1);
    cycle();
    clr_in();

    // 4: SRAM ready after 3 wait cycles
    do_reset();
    hif.mem_req_MEM = 1'b1;
    repeat (3) cycle();
    hif.sram_ready = 1'b1;
    #2 check("t4_ready_unfreeze", 32'(hif.freeze), 32'd0);
    cycle();
    check("t4_stall3", 32'(hif.stall_cnt), 32'd3);
    clr_in();
    cycle();

    // 5: timeout, sticky error, counter saturation, reset clears
    do_reset();
    hif.mem_req_MEM = 1'b1;
    repeat (3) cycle();
    check("t5_no_err_yet", 32'(hif.sram_err), 32'd0);
    cycle();
    check("t5_err", 32'(hif.sram_err), 32'd1);
    clr_in();
    hif.B_EXE = 1'b1;
    repeat (14) cycle();
    check("t5_stall_sat", 32'(hif.stall_cnt), 32'(CMAX));
    check("t5_freeze_stuck", 32'(hif.freeze), 32'd1);
    do_reset();
    check("t5_err_clr", 32'(hif.sram_err), 32'd0);
    clr_in();

    // Async reset mid-WAIT
    hif.mem_req_MEM = 1'b1;
    repeat (2) cycle();
    do_reset();
    clr_in();
    cycle();

    // 6: branch kills load-use offender; freeze suppresses the flush
    hif.B_EXE = 1'b1; hif.WB_EN_EXE = 1'b1; hif.MEM_R_EN_EXE = 1'b1; hif.dest_EXE = 4'd7;
    hif.src1_ID = 4'd7;
    #2 check("t6_flush", 32'(hif.flush), 32'd1);
    cycle();
    check("t6_flush_cnt", 32'(hif.flush_cnt), 32'd1);
    hif.mem_req_MEM = 1'b1;
    #2 check("t6_frozen_flush", 32'(hif.flush), 32'd0);
    cycle();
    hif.sram_ready = 1'b1;
    cycle();
    clr_in();
    cycle();

    // Random traffic with periodic resets
    for (int i = 0; i < 400; i++) begin
      if (i % 60 == 59) do_reset();
      hif.forward_en   = 1'($urandom_range(0, 1));
      hif.src1_ID      = 4'($urandom_range(0, 3));
      hif.src2_ID      = 4'($urandom_range(0, 3));
      hif.two_src_ID   = 1'($urandom_range(0, 1));
      hif.src1_EXE     = 4'($urandom_range(0, 3));
      hif.src2_EXE     = 4'($urandom_range(0, 3));
      hif.dest_EXE     = 4'($urandom_range(0, 3));
      hif.WB_EN_EXE    = 1'($urandom_range(0, 1));
      hif.MEM_R_EN_EXE = 1'($urandom_range(0, 1));
      hif.B_EXE        = ($urandom_range(0, 4) == 0);
      hif.dest_MEM     = 4'($urandom_range(0, 3));
      hif.WB_EN_MEM    = 1'($urandom_range(0, 1));
      hif.mem_req_MEM  = ($urandom_range(0, 3) == 0);
      hif.sram_ready   = 1'($urandom_range(0, 1));
      hif.dest_WB      = 4'($urandom_range(0, 3));
      hif.WB_EN_WB     = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
